// File: rtl/sha3_sponge_ctrl.sv
// SHA3 sponge controller: absorbs message lanes into a rate block,
// applies SHA3 padding and sequences permutations on an external core.
module sha3_sponge_ctrl #(
    parameter int WIDTH      = 64,
    parameter int RATE_LANES = 17
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [WIDTH-1:0]            in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic [3:0]                  in_bytes,
    output logic                        in_ready,
    output logic [RATE_LANES*WIDTH-1:0] core_din,
    output logic                        core_start,
    output logic                        core_last,
    input  logic                        core_done,
    input  logic [255:0]                core_dout,
    output logic [255:0]                digest,
    output logic                        digest_valid,
    output logic                        busy
);

    localparam int LB = WIDTH / 8;
    localparam int BW = RATE_LANES * WIDTH;
    localparam int CW = $clog2(RATE_LANES);
    localparam logic [CW-1:0] LAST_LANE = CW'(RATE_LANES - 1);

    typedef enum logic [2:0] {
        S_ABSORB,
        S_ISSUE,
        S_WAIT,
        S_PADBLK,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   lane_q, lane_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic            pend_last_q, pend_last_d;
    logic            pend_pad_q, pend_pad_d;
    logic [255:0]    digest_q, digest_d;

    logic            accept;
    logic [3:0]      nb;
    logic [WIDTH-1:0] msg_lane;
    logic [BW-1:0]   pad_buf;
    logic [BW-1:0]   pad_blk;

    assign in_ready     = nrst && (state_q == S_ABSORB);
    assign core_start   = nrst && (state_q == S_ISSUE);
    assign core_last    = core_start && pend_last_q;
    assign digest_valid = nrst && (state_q == S_DONE);
    assign busy         = nrst && !((state_q == S_ABSORB) && (lane_q == '0));
    assign core_din     = buf_q;
    assign digest       = digest_q;
    assign accept       = in_valid && in_ready;

    // Final lane: keep nb message bytes, place the 0x06 domain byte after them.
    always_comb begin
        nb = (in_bytes > 4'(LB)) ? 4'(LB) : in_bytes;
        msg_lane = '0;
        for (int k = 0; k < LB; k++) begin
            if (4'(k) < nb)
                msg_lane[k*8 +: 8] = in_data[k*8 +: 8];
            else if (4'(k) == nb)
                msg_lane[k*8 +: 8] = 8'h06;
        end
    end

    // Padded block: earlier lanes kept, later lanes zero, 0x80 ORed at the top.
    always_comb begin
        pad_buf = '0;
        for (int i = 0; i < RATE_LANES; i++) begin
            if (CW'(i) < lane_q)
                pad_buf[i*WIDTH +: WIDTH] = buf_q[i*WIDTH +: WIDTH];
            else if (CW'(i) == lane_q)
                pad_buf[i*WIDTH +: WIDTH] = msg_lane;
            else if ((CW'(i) == lane_q + CW'(1)) && (nb == 4'(LB)))
                pad_buf[i*WIDTH +: WIDTH] = WIDTH'(8'h06);
        end
        pad_buf[BW-1 -: 8] = pad_buf[BW-1 -: 8] | 8'h80;
    end

    // Extra all-padding block used when the message ends on a block boundary.
    always_comb begin
        pad_blk = '0;
        pad_blk[7:0] = 8'h06;
        pad_blk[BW-1 -: 8] = 8'h80;
    end

    // Next-state and datapath updates for the sponge sequencer.
    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        buf_d       = buf_q;
        pend_last_d = pend_last_q;
        pend_pad_d  = pend_pad_q;
        digest_d    = digest_q;
        unique case (state_q)
            S_ABSORB: begin
                if (accept) begin
                    if (!in_last) begin
                        buf_d[lane_q*WIDTH +: WIDTH] = in_data;
                        if (lane_q == LAST_LANE) begin
                            state_d     = S_ISSUE;
                            pend_last_d = 1'b0;
                            pend_pad_d  = 1'b0;
                        end else begin
                            lane_d = lane_q + CW'(1);
                        end
                    end else if ((nb < 4'(LB)) || (lane_q != LAST_LANE)) begin
                        buf_d       = pad_buf;
                        state_d     = S_ISSUE;
                        pend_last_d = 1'b1;
                        pend_pad_d  = 1'b0;
                    end else begin
                        buf_d[lane_q*WIDTH +: WIDTH] = in_data;
                        state_d     = S_ISSUE;
                        pend_last_d = 1'b0;
                        pend_pad_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    if (pend_last_q) begin
                        state_d  = S_DONE;
                        digest_d = core_dout;
                    end else if (pend_pad_q) begin
                        state_d = S_PADBLK;
                    end else begin
                        state_d = S_ABSORB;
                        lane_d  = '0;
                        buf_d   = '0;
                    end
                end
            end
            S_PADBLK: begin
                buf_d       = pad_blk;
                pend_last_d = 1'b1;
                pend_pad_d  = 1'b0;
                state_d     = S_ISSUE;
            end
            S_DONE: begin
                state_d     = S_ABSORB;
                lane_d      = '0;
                buf_d       = '0;
                pend_last_d = 1'b0;
                pend_pad_d  = 1'b0;
            end
            default: begin
                state_d = S_ABSORB;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= S_ABSORB;
            lane_q      <= '0;
            buf_q       <= '0;
            pend_last_q <= 1'b0;
            pend_pad_q  <= 1'b0;
            digest_q    <= '0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            buf_q       <= buf_d;
            pend_last_q <= pend_last_d;
            pend_pad_q  <= pend_pad_d;
            digest_q    <= digest_d;
        end
    end

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Bench for sha3_sponge_ctrl: byte-level SHA3 padding model plus
// a randomized permutation-core responder.
module tb_sha3_sponge_ctrl;

    logic          clk;
    logic          nrst;
    logic [63:0]   in_data;
    logic          in_valid;
    logic          in_last;
    logic [3:0]    in_bytes;
    logic          in_ready;
    logic [1087:0] core_din;
    logic          core_start;
    logic          core_last;
    logic          core_done;
    logic [255:0]  core_dout;
    logic [255:0]  digest;
    logic          digest_valid;
    logic          busy;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] lanes[$];
    logic [7:0]  pb[$];
    int          nblk;

    sha3_sponge_ctrl #(.WIDTH(64), .RATE_LANES(17)) dut (
        .clk(clk), .nrst(nrst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_bytes(in_bytes), .in_ready(in_ready),
        .core_din(core_din), .core_start(core_start), .core_last(core_last),
        .core_done(core_done), .core_dout(core_dout),
        .digest(digest), .digest_valid(digest_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic fill_rand(input int n);
        lanes.delete();
        for (int i = 0; i < n; i++) lanes.push_back({$urandom, $urandom});
    endtask

    task automatic drive(input int n, input int nb_raw, input bit gaps);
        bit acc;
        bit rdy;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            in_valid = 1'b1;
            in_data  = lanes[i];
            in_last  = (i == n - 1);
            in_bytes = (i == n - 1) ? 4'(nb_raw) : 4'($urandom_range(0, 15));
            acc = 1'b0;
            for (int t = 0; t < 300 && !acc; t++) begin
                rdy = in_ready;
                tick();
                acc = rdy;
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (!acc) begin
                chk("accept_timeout", 0, 1);
                return;
            end
            if (i == n - 1 || i % 17 == 16)
                chk("start_latency", 256'(core_start), 1);
            else
                chk("busy_ready_mid", {busy, in_ready}, 2'b11);
        end
    endtask

    task automatic respond();
        logic [1087:0] expblk;
        logic [255:0]  dout;
        bit            seen;
        bit            lastb;
        for (int k = 0; k < nblk; k++) begin
            for (int j = 0; j < 136; j++) expblk[j*8 +: 8] = pb[k*136 + j];
            lastb = (k == nblk - 1);
            seen = 1'b0;
            for (int t = 0; t < 400; t++) begin
                if (core_start) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            chk("start_seen", 256'(seen), 1);
            if (!seen) return;
            chk($sformatf("core_last_b%0d", k), 256'(core_last), 256'(lastb));
            for (int i = 0; i < 17; i++)
                chk($sformatf("din_b%0d_l%0d", k, i),
                    core_din[i*64 +: 64], expblk[i*64 +: 64]);
            tick();
            chk("start_pulse_ready", {core_start, in_ready}, 2'b00);
            repeat ($urandom_range(0, 4)) tick();
            chk("din_hold", 256'(core_din === expblk), 1);
            dout      = rnd256();
            core_dout = dout;
            core_done = 1'b1;
            tick();
            core_done = 1'b0;
            if (lastb) begin
                chk("digest_valid_on", 256'(digest_valid), 1);
                chk("digest_value", digest, dout);
                tick();
                chk("digest_valid_off", 256'(digest_valid), 0);
                chk("digest_hold", digest, dout);
                chk("idle_ready_busy", {in_ready, busy}, 2'b10);
            end
        end
    endtask

    task automatic run_msg(input int nb_raw, input bit gaps);
        int n;
        int nb;
        int lim;
        logic [63:0] l;
        n  = lanes.size();
        nb = (nb_raw > 8) ? 8 : nb_raw;
        pb.delete();
        for (int i = 0; i < n; i++) begin
            l   = lanes[i];
            lim = (i == n - 1) ? nb : 8;
            for (int j = 0; j < lim; j++) pb.push_back(l[j*8 +: 8]);
        end
        pb.push_back(8'h06);
        while (pb.size() % 136 != 0) pb.push_back(8'h00);
        pb[pb.size() - 1] = pb[pb.size() - 1] | 8'h80;
        nblk = pb.size() / 136;
        fork
            drive(n, nb_raw, gaps);
            respond();
        join
        tick();
    endtask

    initial begin
        logic [63:0] l;
        nrst      = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_bytes  = '0;
        core_done = 1'b0;
        core_dout = '0;
        repeat (3) tick();
        chk("rst_in_ready", 256'(in_ready), 0);
        chk("rst_core_start", 256'(core_start), 0);
        chk("rst_digest_valid", 256'(digest_valid), 0);
        chk("rst_busy", 256'(busy), 0);
        chk("rst_digest", digest, 0);
        nrst = 1'b1;
        #1;
        chk("ready_after_rst", 256'(in_ready), 1);
        tick();
        chk("idle_busy", 256'(busy), 0);

        core_dout = rnd256();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("spurious_state", {in_ready, busy, core_start, digest_valid}, 4'b1000);
        chk("spurious_digest", digest, 0);

        fill_rand(1);
        run_msg(0, 1'b0);

        fill_rand(17);
        run_msg(8, 1'b0);

        fill_rand(17);
        lanes[16] = 64'h00AABBCCDDEEFF11;
        run_msg(7, 1'b0);
        chk("byte135_combined", 256'(pb[135]), 256'(8'h86));

        fill_rand(3);
        l = lanes[2];
        l[23:0] = 24'h332211;
        lanes[2] = l;
        run_msg(3, 1'b1);

        fill_rand(5);
        run_msg(12, 1'b1);

        in_valid = 1'b1;
        in_last  = 1'b1;
        in_bytes = 4'd2;
        in_data  = {$urandom, $urandom};
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("abort_issue", 256'(core_start), 1);
        tick();
        chk("abort_wait", {in_ready, busy, core_start}, 3'b010);
        nrst = 1'b0;
        tick();
        chk("abort_rst_outs", {in_ready, busy, core_start, digest_valid}, 4'b0000);
        chk("abort_rst_digest", digest, 0);
        nrst = 1'b1;
        #1;
        chk("abort_ready_rel", 256'(in_ready), 1);
        core_dout = rnd256();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("abort_no_dv", {digest_valid, in_ready, busy}, 3'b010);
        chk("abort_digest", digest, 0);
        tick();
        chk("abort_no_dv2", 256'(digest_valid), 0);

        for (int m = 0; m < 6; m++) begin
            fill_rand($urandom_range(1, 40));
            run_msg($urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sha3_sponge_ctrl.md
SHA3_SPONGE_CTRL -- requirements
Module: sha3_sponge_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 64: lane width in bits.
REQ-002 SHALL have parameter RATE_LANES, default 17: lanes per rate block (SHA3-256, 136 bytes).
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port nrst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_data, input, WIDTH: message lane; byte k at bits [8k+7:8k].
REQ-006 SHALL have port in_valid, input, 1: in_data valid.
REQ-007 SHALL have port in_last, input, 1: final lane of the message.
REQ-008 SHALL have port in_bytes, input, 4: valid bytes in the last lane, 0..8; values 9..15 are treated as 8; ignored when in_last=0.
REQ-009 SHALL have port in_ready, output, 1: lane accepted when in_valid & in_ready.
REQ-010 SHALL have port core_din, output, RATE_LANES*WIDTH: rate block, lane i at bits [64i+63:64i].
REQ-011 SHALL have port core_start, output, 1: one-cycle pulse requesting a permutation of core_din.
REQ-012 SHALL have port core_last, output, 1: the issued block is the final block; valid while core_start=1.
REQ-013 SHALL have port core_done, input, 1: one-cycle pulse from the permutation core.
REQ-014 SHALL have port core_dout, input, 256: digest lanes 0..3 from the core.
REQ-015 SHALL have port digest, output, 256: captured digest.
REQ-016 SHALL have port digest_valid, output, 1: one-cycle pulse when digest updates.
REQ-017 SHALL have port busy, output, 1: high in every state except ABSORB with lane count 0.

Function
REQ-018 SHALL implement the states ABSORB, ISSUE, WAIT, PADBLK and DONE.
REQ-019 ABSORB SHALL drive in_ready=1, write accepted lanes into buffer[lane_cnt], and increment lane_cnt (0..RATE_LANES-1).
REQ-020 On a non-last accept at lane_cnt=RATE_LANES-1, ABSORB SHALL go to ISSUE with pend_last=0 and pend_pad=0.
REQ-021 On an accept with in_last=1 and (in_bytes<8 or lane_cnt<RATE_LANES-1), ABSORB SHALL store the masked bytes, place 0x06 at the byte after the message, OR 0x80 into byte 135, zero the remaining bytes, then go to ISSUE with pend_last=1.
REQ-022 On an accept with in_last=1, in_bytes=8 and lane_cnt=RATE_LANES-1, ABSORB SHALL go to ISSUE with pend_last=0 and pend_pad=1.
REQ-023 Padding SHALL combine, never overwrite: message end at byte 135 SHALL yield byte 135 = 0x86.
REQ-024 ISSUE SHALL pulse core_start for exactly 1 cycle with core_last=pend_last and core_din=buffer, then go to WAIT.
REQ-025 core_din SHALL be held stable from ISSUE until core_done.
REQ-026 In WAIT, in_ready SHALL be 0; on core_done it SHALL go to DONE if pend_last=1, to PADBLK if pend_pad=1, else to ABSORB with lane_cnt=0 and the buffer cleared.
REQ-027 PADBLK SHALL load the buffer with all zeros except byte 0 = 0x06 and byte 135 = 0x80, set pend_last=1 and pend_pad=0, then go to ISSUE (1 cycle).
REQ-028 On entry to DONE, digest SHALL be loaded with the core_dout value sampled on the core_done cycle, and digest_valid SHALL pulse 1 cycle in DONE.
REQ-029 DONE SHALL then go to ABSORB with lane_cnt=0 and the buffer cleared; digest SHALL hold until the next DONE.
REQ-030 core_done outside WAIT SHALL be ignored.
REQ-031 in_valid outside ABSORB SHALL be ignored and SHALL NOT be consumed.
REQ-032 Latency from the final accept to core_start SHALL be 1 cycle; from core_done to digest_valid SHALL be 1 cycle.
REQ-033 The message length SHALL be unbounded; lane_cnt SHALL wrap only through ISSUE/WAIT.

Reset
REQ-034 While nrst=0 at a clock edge, the block SHALL enter ABSORB and clear lane_cnt, the buffer, pend_last and pend_pad.
REQ-035 While nrst=0 at a clock edge, digest SHALL be set to 0 and in_ready, core_start, digest_valid and busy SHALL be 0.
REQ-036 A reset asserted in any state, including WAIT, SHALL abort the message; a core_done arriving after the reset SHALL be ignored.
REQ-037 in_ready SHALL be 1 in the first cycle after nrst rises.

Verification
REQ-038 Empty message (in_last=1, in_bytes=0 at lane 0) -> one core_start with core_last=1, lane0=0x06, lane16=0x8000000000000000, lanes1..15=0.
REQ-039 17 full lanes, last with in_bytes=8 -> first start core_last=0; after core_done, second start core_last=1 with lane0=0x06, lane16=0x8000000000000000.
REQ-040 16 full lanes plus last lane 0x00AABBCCDDEEFF11 with in_bytes=7 -> lane16=0x86AABBCCDDEEFF11, single start, core_last=1.
REQ-041 3 lanes with in_valid gaps, last in_bytes=3 data 0x...332211 -> lane2=0x0000000006332211, lane16=0x8000000000000000; in_ready=0 from ISSUE until ABSORB.
REQ-042 nrst=0 during WAIT, then core_done pulse -> no digest_valid, digest=0, in_ready=1 after release.
REQ-043 Spurious core_done in ABSORB -> no state change; a normal digest -> digest_valid 1 cycle after core_done, digest=core_dout.
